// File: rtl/jtframe_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM readers.
// Each slot owns a one-word cache (tag, valid, data), so a repeated read of
// the same word is answered combinationally without touching SDRAM.
module jtframe_rom_arb #(
  parameter int                 SLOTS     = 4,
  parameter int                 AW        = 22,
  parameter logic [2*SLOTS-1:0] SLOT_BANK = {SLOTS{2'b00}}
) (
  input  logic                clk_rom,
  input  logic                rst,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*32-1:0] slot_dout,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [AW-1:0]       sdram_addr,
  output logic [1:0]          sdram_bank,
  input  logic [31:0]         data_read,
  input  logic                data_rdy,
  output logic                refresh_en
);

  localparam int CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_DATA
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cur_q, cur_d;
  logic [CW-1:0]             last_q, last_d;
  logic                      req_q, req_d;
  logic [AW-1:0]             addr_q, addr_d;      // captured request address
  logic [1:0]                bank_q, bank_d;
  logic [SLOTS-1:0]          valid_q, valid_d;
  logic [SLOTS-1:0][AW-1:0]  tag_q;
  logic [SLOTS-1:0][31:0]    dout_q;
  logic                      fill_en;

  logic [SLOTS-1:0]          hit;
  logic [SLOTS-1:0]          pending;
  logic                      busy;
  logic                      flush;
  logic                      grant_found;
  logic [CW-1:0]             grant_idx;
  logic [CW:0]               rr_sum;
  logic [AW-1:0]             grant_addr;
  logic [1:0]                grant_bank;

  assign busy  = (state_q != ST_IDLE);
  assign flush = downloading | loop_rst;

  // Per-slot cache hit, data-valid and outstanding-miss flags.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      hit[i]     = valid_q[i] && (slot_addr[AW*i +: AW] == tag_q[i]);
      slot_ok[i] = slot_req[i] & hit[i];
      // The slot currently being served is not pending again until it returns.
      pending[i] = slot_req[i] & ~hit[i] & ~(busy && (cur_q == CW'(i)));
    end
  end

  // Round-robin search: first pending slot starting after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      rr_sum = {1'b0, last_q} + (CW+1)'(k);
      if (rr_sum >= (CW+1)'(SLOTS)) rr_sum = rr_sum - (CW+1)'(SLOTS);
      if (!grant_found && pending[rr_sum[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = rr_sum[CW-1:0];
      end
    end
  end

  // Address and bank of the granted slot.
  always_comb begin
    grant_addr = '0;
    grant_bank = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (grant_idx == CW'(i)) begin
        grant_addr = slot_addr[AW*i +: AW];
        grant_bank = SLOT_BANK[2*i +: 2];
      end
    end
  end

  // Next-state logic; flush overrides every other event in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    req_d   = req_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    valid_d = valid_q;
    fill_en = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            cur_d   = grant_idx;
            last_d  = grant_idx;
            addr_d  = grant_addr;
            bank_d  = grant_bank;
            req_d   = 1'b1;
            state_d = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            state_d = ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (data_rdy) begin
            fill_en        = 1'b1;
            valid_d[cur_q] = 1'b1;
            state_d        = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // State, request and per-slot data registers.
  always_ff @(posedge clk_rom or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= CW'(SLOTS-1);
      req_q   <= 1'b0;
      addr_q  <= '0;
      bank_q  <= '0;
      valid_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      if (fill_en) dout_q[cur_q] <= data_read;
    end
  end

  // Cache tags are written on fill only.
  always_ff @(posedge clk_rom) begin
    // NOTE: tags are left without reset; valid_q gates every use of them.
    if (fill_en) tag_q[cur_q] <= addr_q;
  end

  assign slot_dout  = dout_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign sdram_bank = bank_q;
  assign refresh_en = (state_q == ST_IDLE) & ~(|pending) & ~downloading;

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb: reset, miss/hit, round-robin order,
// mid-transaction address change, download flush and asynchronous reset.
module tb_jtframe_rom_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam logic [2*SLOTS-1:0] BANKS = 8'b00_10_00_00;  // slot2 -> bank 2

  logic                clk_rom;
  logic                rst;
  logic                downloading;
  logic                loop_rst;
  logic [SLOTS-1:0]    slot_req;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*32-1:0] slot_dout;
  logic                sdram_req;
  logic                sdram_ack;
  logic [AW-1:0]       sdram_addr;
  logic [1:0]          sdram_bank;
  logic [31:0]         data_read;
  logic                data_rdy;
  logic                refresh_en;

  int tests_run    = 0;
  int tests_failed = 0;

  jtframe_rom_arb #(
    .SLOTS     (SLOTS),
    .AW        (AW),
    .SLOT_BANK (BANKS)
  ) dut (
    .clk_rom     (clk_rom),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot_req    (slot_req),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_addr  (sdram_addr),
    .sdram_bank  (sdram_bank),
    .data_read   (data_read),
    .data_rdy    (data_rdy),
    .refresh_en  (refresh_en)
  );

  initial clk_rom = 1'b0;
  always #5 clk_rom = ~clk_rom;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    slot_addr[AW*i +: AW] = a;
  endtask

  function automatic logic [31:0] dout_of(input int i);
    return slot_dout[32*i +: 32];
  endfunction

  task automatic wait_req(input string name, output int cycles);
    cycles = -1;
    for (int c = 0; c < 40; c++) begin
      if (sdram_req === 1'b1) begin
        cycles = c;
        break;
      end
      tick();
    end
    tests_run++;
    if (cycles < 0) begin
      tests_failed++;
      $display("FAIL %s_req_timeout: got sdram_req=0 exp=1 within 40 cycles", name);
    end
  endtask

  task automatic do_ack(input string name);
    tick();
    tests_run++;
    if (sdram_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_req_hold: got=%b exp=1", name, sdram_req);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tests_run++;
    if (sdram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_req_clear: got=%b exp=0", name, sdram_req);
    end
  endtask

  task automatic do_data(input string name, input int slot, input logic [31:0] data);
    tick();
    data_read = data;
    data_rdy  = 1'b1;
    #1;
    tests_run++;
    if (slot_ok[slot] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_ok_early: got=%b exp=0", name, slot_ok[slot]);
    end
    tick();
    data_rdy = 1'b0;
    tests_run++;
    if (sdram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle_gap: got sdram_req=%b exp=0", name, sdram_req);
    end
  endtask

  task automatic serve(input string name, input int slot, input logic [AW-1:0] exp_addr,
                       input logic [1:0] exp_bank, input logic [31:0] data, output int cycles);
    wait_req(name, cycles);
    if (cycles < 0) return;
    tests_run++;
    if (sdram_addr !== exp_addr) begin
      tests_failed++;
      $display("FAIL %s_addr: got=%h exp=%h", name, sdram_addr, exp_addr);
    end
    tests_run++;
    if (sdram_bank !== exp_bank) begin
      tests_failed++;
      $display("FAIL %s_bank: got=%b exp=%b", name, sdram_bank, exp_bank);
    end
    do_ack(name);
    do_data(name, slot, data);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    slot_req  = '0;
    slot_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int cyc;
    apply_reset();
    tests_run++;
    if (slot_ok !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ok: got=%b exp=0000", slot_ok);
    end
    tests_run++;
    if (sdram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_req: got=%b exp=0", sdram_req);
    end
    tests_run++;
    if (refresh_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_refresh: got=%b exp=1", refresh_en);
    end
    tests_run++;
    if (slot_dout !== '0) begin
      tests_failed++;
      $display("FAIL reset_dout: got=%h exp=0", slot_dout);
    end
    set_addr(0, 22'h000100);
    slot_req[0] = 1'b1;
    #1;
    tests_run++;
    if (refresh_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss0_refresh: got=%b exp=0", refresh_en);
    end
    serve("miss0", 0, 22'h000100, 2'b00, 32'hDEADBEEF, cyc);
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL miss0_latency: got=%0d exp=1", cyc);
    end
    tests_run++;
    if (slot_ok[0] !== 1'b1 || dout_of(0) !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL miss0_fill: got ok=%b dout=%h exp ok=1 dout=deadbeef", slot_ok[0], dout_of(0));
    end
  endtask

  task automatic test_hit();
    int cyc;
    int req_seen = 0;
    tests_run++;
    if (slot_ok[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit0_ok: got=%b exp=1", slot_ok[0]);
    end
    // A stray ack in IDLE must be ignored.
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (sdram_req !== 1'b0) req_seen++;
      tick();
    end
    tests_run++;
    if (req_seen != 0) begin
      tests_failed++;
      $display("FAIL hit0_no_req: got %0d req cycles exp 0", req_seen);
    end
    set_addr(0, 22'h000102);
    #1;
    tests_run++;
    if (slot_ok[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL newaddr0_ok_drop: got=%b exp=0", slot_ok[0]);
    end
    serve("newaddr0", 0, 22'h000102, 2'b00, 32'h01020304, cyc);
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL newaddr0_latency: got=%0d exp=1", cyc);
    end
    tests_run++;
    if (slot_ok[0] !== 1'b1 || dout_of(0) !== 32'h01020304) begin
      tests_failed++;
      $display("FAIL newaddr0_fill: got ok=%b dout=%h exp ok=1 dout=01020304", slot_ok[0], dout_of(0));
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    apply_reset();
    set_addr(0, 22'h000200);
    set_addr(1, 22'h000300);
    set_addr(2, 22'h000400);
    set_addr(3, 22'h000500);
    slot_req = 4'b1111;
    serve("rr_s0", 0, 22'h000200, 2'b00, 32'hA0000200, cyc);
    serve("rr_s1", 1, 22'h000300, 2'b00, 32'hA1000300, cyc);
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL rr_back_to_back: got=%0d exp=1", cyc);
    end
    wait_req("rr_s2", cyc);
    tests_run++;
    if (sdram_addr !== 22'h000400 || sdram_bank !== 2'b10) begin
      tests_failed++;
      $display("FAIL rr_s2_req: got addr=%h bank=%b exp addr=000400 bank=10", sdram_addr, sdram_bank);
    end
    set_addr(0, 22'h000204);
    #1;
    tests_run++;
    if (slot_ok[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_s0_remiss: got=%b exp=0", slot_ok[0]);
    end
    do_ack("rr_s2");
    do_data("rr_s2", 2, 32'hA2000400);
    serve("rr_s3_first", 3, 22'h000500, 2'b00, 32'hA3000500, cyc);
    serve("rr_s0_after", 0, 22'h000204, 2'b00, 32'hA0000204, cyc);
    tests_run++;
    if (slot_ok !== 4'b1111) begin
      tests_failed++;
      $display("FAIL rr_all_ok: got=%b exp=1111", slot_ok);
    end
    tests_run++;
    if (dout_of(0) !== 32'hA0000204 || dout_of(1) !== 32'hA1000300 ||
        dout_of(2) !== 32'hA2000400 || dout_of(3) !== 32'hA3000500) begin
      tests_failed++;
      $display("FAIL rr_dout: got=%h exp=a3000500a2000400a1000300a0000204", slot_dout);
    end
  endtask

  task automatic test_addr_change();
    int cyc;
    set_addr(2, 22'h000404);
    wait_req("chg_s2", cyc);
    tests_run++;
    if (sdram_addr !== 22'h000404 || sdram_bank !== 2'b10) begin
      tests_failed++;
      $display("FAIL chg_s2_req: got addr=%h bank=%b exp addr=000404 bank=10", sdram_addr, sdram_bank);
    end
    set_addr(2, 22'h000408);
    do_ack("chg_s2");
    do_data("chg_s2", 2, 32'hA5A50404);
    tests_run++;
    if (slot_ok[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL chg_s2_ok_new: got=%b exp=0", slot_ok[2]);
    end
    set_addr(2, 22'h000404);
    #1;
    tests_run++;
    if (slot_ok[2] !== 1'b1 || dout_of(2) !== 32'hA5A50404) begin
      tests_failed++;
      $display("FAIL chg_s2_old_tag: got ok=%b dout=%h exp ok=1 dout=a5a50404", slot_ok[2], dout_of(2));
    end
    set_addr(2, 22'h000408);
    #1;
    serve("chg_s2_refetch", 2, 22'h000408, 2'b10, 32'h5A5A0408, cyc);
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL chg_s2_refetch_latency: got=%0d exp=1", cyc);
    end
    tests_run++;
    if (slot_ok[2] !== 1'b1 || dout_of(2) !== 32'h5A5A0408) begin
      tests_failed++;
      $display("FAIL chg_s2_refetch_fill: got ok=%b dout=%h exp ok=1 dout=5a5a0408", slot_ok[2], dout_of(2));
    end
  endtask

  task automatic test_download();
    int cyc;
    set_addr(1, 22'h000310);
    wait_req("dl_s1", cyc);
    do_ack("dl_s1");
    tick();
    // Flush and data arrive together; flush must win.
    downloading = 1'b1;
    data_read   = 32'hBADBAD00;
    data_rdy    = 1'b1;
    tick();
    downloading = 1'b0;
    data_rdy    = 1'b0;
    tests_run++;
    if (sdram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL dl_req: got=%b exp=0", sdram_req);
    end
    tests_run++;
    if (slot_ok !== 4'b0000) begin
      tests_failed++;
      $display("FAIL dl_ok_flushed: got=%b exp=0000", slot_ok);
    end
    tests_run++;
    if (dout_of(1) !== 32'hA1000300) begin
      tests_failed++;
      $display("FAIL dl_data_ignored: got=%h exp=a1000300", dout_of(1));
    end
    // last = 1, so refetch order is 2, 3, 0, 1.
    serve("dl_re_s2", 2, 22'h000408, 2'b10, 32'hB2000408, cyc);
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL dl_re_latency: got=%0d exp=1", cyc);
    end
    serve("dl_re_s3", 3, 22'h000500, 2'b00, 32'hB3000500, cyc);
    serve("dl_re_s0", 0, 22'h000204, 2'b00, 32'hB0000204, cyc);
    serve("dl_re_s1", 1, 22'h000310, 2'b00, 32'hB1000310, cyc);
    tests_run++;
    if (slot_ok !== 4'b1111 || dout_of(1) !== 32'hB1000310) begin
      tests_failed++;
      $display("FAIL dl_refetch: got ok=%b dout1=%h exp ok=1111 dout1=b1000310", slot_ok, dout_of(1));
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    set_addr(3, 22'h000520);
    wait_req("ar_s3", cyc);
    tests_run++;
    if (sdram_addr !== 22'h000520) begin
      tests_failed++;
      $display("FAIL ar_s3_addr: got=%h exp=000520", sdram_addr);
    end
    #2;
    rst      = 1'b1;
    slot_req = '0;
    #1;
    tests_run++;
    if (sdram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL ar_req_async: got=%b exp=0", sdram_req);
    end
    tests_run++;
    if (sdram_addr !== '0 || sdram_bank !== 2'b00) begin
      tests_failed++;
      $display("FAIL ar_addr_bank: got addr=%h bank=%b exp 0/00", sdram_addr, sdram_bank);
    end
    tests_run++;
    if (slot_ok !== 4'b0000 || slot_dout !== '0) begin
      tests_failed++;
      $display("FAIL ar_slots: got ok=%b dout=%h exp 0", slot_ok, slot_dout);
    end
    tests_run++;
    if (refresh_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL ar_refresh: got=%b exp=1", refresh_en);
    end
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (sdram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL ar_after_release: got=%b exp=0", sdram_req);
    end
  endtask

  initial begin
    rst         = 1'b1;
    downloading = 1'b0;
    loop_rst    = 1'b0;
    slot_req    = '0;
    slot_addr   = '0;
    sdram_ack   = 1'b0;
    data_read   = '0;
    data_rdy    = 1'b0;
    test_reset();
    test_hit();
    test_round_robin();
    test_addr_change();
    test_download();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
